prog_sched: RTL and testbench
=============================

# prog_sched

Program launch sequencer between the external `req`/`ack` handshake and the processor core. Each `req` rising edge selects the next of three programs in fixed order (1→2→3→1), issues a one-cycle start with that program's entry PC, and holds the core enabled until it reports halt. `ack` is then raised and held until the next request. The block also counts run cycles per program and, optionally, aborts runaway programs with a watchdog.

## Interface
Parameters:
- `PC_W`, 10: width of program counter / entry address
- `PROG1_PC`, 0: entry PC of program 1
- `PROG2_PC`, 256: entry PC of program 2
- `PROG3_PC`, 512: entry PC of program 3
- `WDOG_W`, 16: watchdog counter width (used only with `PROG_SCHED_WDOG_EN`)

Ports:
- `clk` in 1: single clock, all state on rising edge
- `reset` in 1: asynchronous, active-high reset
- `req` in 1: start-next-program request, level from bench, edge-detected internally
- `halt` in 1: core has executed its halt instruction
- `ack` out 1: current program done, held until next accepted request
- `start` out 1: one-cycle pulse, core loads `start_pc`
- `start_pc` out PC_W: entry PC of selected program, valid while `start`=1
- `run` out 1: core execute enable
- `prog_id` out 2: program currently or last launched (0 = none since reset, else 1..3)
- `cyc_cnt` out 32: cycles spent in RUN for current/last program
- `timeout` out 1: last program was aborted by watchdog

## Operation
- States: IDLE, LAUNCH, RUN, DONE. Reset state IDLE.
- Request edge: `req_q` register; accepted edge = `req & ~req_q`, evaluated only in IDLE or DONE. Edges in LAUNCH/RUN are discarded, not queued.
- IDLE/DONE → LAUNCH on accepted edge: `prog_id` ← next (0→1, 1→2, 2→3, 3→1), `ack`←0, `timeout`←0, `cyc_cnt`←0.
- LAUNCH (1 cycle): `start`=1, `start_pc` = table[`prog_id`], `run`=0; `halt` ignored. Next state RUN.
- RUN: `run`=1; `cyc_cnt` increments each cycle, saturating at 0xFFFF_FFFF. On `halt`=1 → DONE.
- DONE: `run`=0, `ack`=1, `cyc_cnt` and `prog_id` hold. `ack` falls only on next accepted edge.
- `start_pc` is 0 outside LAUNCH.
- Reset values: `ack`=0, `start`=0, `start_pc`=0, `run`=0, `prog_id`=0, `cyc_cnt`=0, `timeout`=0, `req_q`=0. A reset mid-RUN aborts the program; the next request launches program 1.

## Timing
- Edge E samples `req`=1 with `req_q`=0 → after E: state LAUNCH, `start`=1. Request-to-start latency: 1 edge.
- Edge E+1 → RUN, `run`=1, `start`=0.
- The first RUN cycle counts. `cyc_cnt` equals the number of edges sampled in RUN, including the halting edge.
- `halt` sampled high at edge H in RUN → after H: DONE, `ack`=1, `run`=0.
- Requests separated by a single high cycle are sufficient. A `req` held high launches only once.
- `req` rising at the same edge `halt` is sampled in RUN: the halt is honored and the request is dropped.

## Configuration
- `PROG_SCHED_WDOG_EN` defined: a WDOG_W-bit counter clears on LAUNCH and increments in RUN. When it reaches 2^WDOG_W−1 with no `halt`, the next state is DONE with `timeout`=1 and `ack`=1. A `halt` on the same edge takes priority, and `timeout` stays 0.
- Not defined: no watchdog logic. `timeout` is tied to 0, and RUN waits indefinitely for `halt`.

## Test plan
- Reset, then `req` pulse, with `halt` driven 20 cycles after `start` → `start_pc`=0, `prog_id`=1, `ack`=1 one edge after halt, `cyc_cnt`=20.
- Three successive req/halt rounds, then a fourth → `start_pc` sequence 0, 256, 512, 0; `prog_id` sequence 1, 2, 3, 1.
- `req` pulse during RUN → no second `start`, `prog_id` unchanged, `ack` stays 0 until halt.
- Assert `reset` mid-RUN for 1 cycle, then `req` → all outputs at reset values immediately, then `prog_id`=1, `start_pc`=0.
- `req` held high through a whole program and after `ack` → exactly one launch; `ack` stays 1.
- With `PROG_SCHED_WDOG_EN` and `WDOG_W`=4, never assert `halt` → DONE after 15 RUN cycles with `timeout`=1 and `ack`=1. Without the macro, the same stimulus gives `run` still 1 after 100 cycles and `timeout`=0.

Source files
------------

// File: rtl/prog_sched.sv
// Program launch sequencer: req edge -> one-cycle start with entry PC -> run until halt -> ack.
// Optional watchdog abort of runaway programs, enabled by defining PROG_SCHED_WDOG_EN.
module prog_sched #(
  parameter int unsigned PC_W     = 10,
  parameter int unsigned PROG1_PC = 0,
  parameter int unsigned PROG2_PC = 256,
  parameter int unsigned PROG3_PC = 512,
  parameter int unsigned WDOG_W   = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req,
  input  logic            halt,
  output logic            ack,
  output logic            start,
  output logic [PC_W-1:0] start_pc,
  output logic            run,
  output logic [1:0]      prog_id,
  output logic [31:0]     cyc_cnt,
  output logic            timeout
);

  typedef enum logic [1:0] {StIdle, StLaunch, StRun, StDone} state_e;

  state_e      state_q, state_d;
  logic        req_q;
  logic [1:0]  prog_id_q, prog_id_d;
  logic [31:0] cyc_cnt_q, cyc_cnt_d;
  logic        req_edge;
  logic        wdog_expire;

`ifdef PROG_SCHED_WDOG_EN
  logic [WDOG_W-1:0] wdog_q, wdog_d, wdog_inc;
  logic              timeout_q, timeout_d;

  always_comb begin
    wdog_inc    = wdog_q + 1'b1;
    wdog_d      = wdog_q;
    wdog_expire = 1'b0;
    if (state_q == StLaunch) begin
      wdog_d = '0;
    end else if (state_q == StRun) begin
      wdog_d      = wdog_inc;
      // Expire on the RUN edge that brings the counter to all-ones.
      wdog_expire = &wdog_inc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_wdog_w;
  assign unused_wdog_w = (WDOG_W != 0);
  assign wdog_expire   = 1'b0;
  assign timeout       = 1'b0;
`endif

  assign req_edge = req & ~req_q;

  always_comb begin
    state_d   = state_q;
    prog_id_d = prog_id_q;
    cyc_cnt_d = cyc_cnt_q;
`ifdef PROG_SCHED_WDOG_EN
    timeout_d = timeout_q;
`endif
    unique case (state_q)
      StIdle, StDone: begin
        if (req_edge) begin
          state_d   = StLaunch;
          prog_id_d = (prog_id_q == 2'd3) ? 2'd1 : prog_id_q + 2'd1;
          cyc_cnt_d = '0;
`ifdef PROG_SCHED_WDOG_EN
          timeout_d = 1'b0;
`endif
        end
      end
      StLaunch: state_d = StRun;
      StRun: begin
        if (cyc_cnt_q != 32'hFFFF_FFFF) cyc_cnt_d = cyc_cnt_q + 32'd1;
        // Halt wins over a watchdog expiry on the same edge.
        if (halt) begin
          state_d = StDone;
        end else if (wdog_expire) begin
          state_d = StDone;
`ifdef PROG_SCHED_WDOG_EN
          timeout_d = 1'b1;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      req_q     <= 1'b0;
      prog_id_q <= 2'd0;
      cyc_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req;
      prog_id_q <= prog_id_d;
      cyc_cnt_q <= cyc_cnt_d;
    end
  end

  always_comb begin
    start_pc = '0;
    if (state_q == StLaunch) begin
      unique case (prog_id_q)
        2'd1:    start_pc = PC_W'(PROG1_PC);
        2'd2:    start_pc = PC_W'(PROG2_PC);
        2'd3:    start_pc = PC_W'(PROG3_PC);
        default: start_pc = '0;
      endcase
    end
  end

  assign start   = (state_q == StLaunch);
  assign run     = (state_q == StRun);
  assign ack     = (state_q == StDone);
  assign prog_id = prog_id_q;
  assign cyc_cnt = cyc_cnt_q;

endmodule

// File: tb/tb_prog_sched.sv
// Directed self-checking bench for prog_sched (WDOG_W=4 so the watchdog path is short).
module tb_prog_sched;

  logic        clk;
  logic        reset;
  logic        req;
  logic        halt;
  logic        ack;
  logic        start;
  logic [9:0]  start_pc;
  logic        run;
  logic [1:0]  prog_id;
  logic [31:0] cyc_cnt;
  logic        timeout;

  int total;
  int bad;
  int n_starts;
  int base;

  prog_sched #(
    .PC_W    (10),
    .PROG1_PC(0),
    .PROG2_PC(256),
    .PROG3_PC(512),
    .WDOG_W  (4)
  ) u_dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .halt    (halt),
    .ack     (ack),
    .start   (start),
    .start_pc(start_pc),
    .run     (run),
    .prog_id (prog_id),
    .cyc_cnt (cyc_cnt),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (start) n_starts = n_starts + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".ack"}, 32'(ack), 0);
    chk({tag, ".start"}, 32'(start), 0);
    chk({tag, ".start_pc"}, 32'(start_pc), 0);
    chk({tag, ".run"}, 32'(run), 0);
    chk({tag, ".prog_id"}, 32'(prog_id), 0);
    chk({tag, ".cyc_cnt"}, cyc_cnt, 0);
    chk({tag, ".timeout"}, 32'(timeout), 0);
  endtask

  // Drive a req edge; check LAUNCH then first RUN cycle.
  task automatic launch(input int exp_pc, input int exp_id, input bit hold);
    req = 1'b1;
    tick();
    chk("launch.start", 32'(start), 1);
    chk("launch.start_pc", 32'(start_pc), 32'(exp_pc));
    chk("launch.prog_id", 32'(prog_id), 32'(exp_id));
    chk("launch.ack", 32'(ack), 0);
    chk("launch.run", 32'(run), 0);
    chk("launch.cyc_cnt", cyc_cnt, 0);
    chk("launch.timeout", 32'(timeout), 0);
    if (!hold) req = 1'b0;
    tick();
    chk("run1.run", 32'(run), 1);
    chk("run1.start", 32'(start), 0);
    chk("run1.start_pc", 32'(start_pc), 0);
  endtask

  // n RUN edges, halt on the last one; expect DONE with exp_cnt.
  task automatic finish(input int n, input int exp_cnt);
    for (int i = 1; i < n; i++) tick();
    chk("prehalt.ack", 32'(ack), 0);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("done.ack", 32'(ack), 1);
    chk("done.run", 32'(run), 0);
    chk("done.cyc_cnt", cyc_cnt, 32'(exp_cnt));
    chk("done.timeout", 32'(timeout), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    total = 0; bad = 0; n_starts = 0;
    reset = 1'b1; req = 1'b0; halt = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk_reset_vals("reset");
    tick();
    chk_reset_vals("idle");

    // Four rounds: program order 1,2,3,1
    launch(0, 1, 0);   finish(20, 20);
    chk("r1.prog_id", 32'(prog_id), 1);
    launch(256, 2, 0); finish(3, 3);
    launch(512, 3, 0); finish(5, 5);
    launch(0, 1, 0);   finish(2, 2);
    tick();
    chk("done_hold.ack", 32'(ack), 1);
    chk("done_hold.cyc_cnt", cyc_cnt, 2);

    // req pulse during RUN is discarded
    base = n_starts;
    launch(256, 2, 0);
    tick(); tick();
    req = 1'b1;
    tick();
    req = 1'b0;
    chk("midreq.start", 32'(start), 0);
    chk("midreq.prog_id", 32'(prog_id), 2);
    chk("midreq.ack", 32'(ack), 0);
    chk("midreq.run", 32'(run), 1);
    tick();
    chk("midreq.start2", 32'(start), 0);
    finish(3, 7);
    chk("midreq.nstarts", 32'(n_starts - base), 1);

    // req rising on the halting edge: halt honoured, req dropped
    launch(512, 3, 0);
    halt = 1'b1; req = 1'b1;
    tick();
    halt = 1'b0;
    chk("race.ack", 32'(ack), 1);
    chk("race.start", 32'(start), 0);
    chk("race.cyc_cnt", cyc_cnt, 1);
    tick();
    req = 1'b0;
    chk("race.ack2", 32'(ack), 1);
    chk("race.prog_id", 32'(prog_id), 3);
    tick();

    // Reset mid-RUN; next launch is program 1
    launch(0, 1, 0);
    tick(); tick(); tick();
    reset = 1'b1;
    #1;
    chk_reset_vals("midreset");
    tick();
    reset = 1'b0;
    tick();
    launch(0, 1, 0);
    finish(2, 2);

    // req held high: exactly one launch, ack stays up
    base = n_starts;
    launch(256, 2, 1);
    finish(4, 4);
    for (int i = 0; i < 5; i++) tick();
    chk("held.ack", 32'(ack), 1);
    chk("held.nstarts", 32'(n_starts - base), 1);
    chk("held.prog_id", 32'(prog_id), 2);
    req = 1'b0;
    tick();

    // No halt: watchdog abort, or indefinite RUN without it
    launch(512, 3, 0);
`ifdef PROG_SCHED_WDOG_EN
    for (int i = 0; i < 14; i++) tick();
    chk("wdog.run14", 32'(run), 1);
    chk("wdog.ack14", 32'(ack), 0);
    tick();
    chk("wdog.ack", 32'(ack), 1);
    chk("wdog.run", 32'(run), 0);
    chk("wdog.timeout", 32'(timeout), 1);
    chk("wdog.cyc_cnt", cyc_cnt, 15);
    tick();
    launch(0, 1, 0);
    finish(1, 1);
`else
    for (int i = 0; i < 100; i++) tick();
    chk("nowdog.run", 32'(run), 1);
    chk("nowdog.timeout", 32'(timeout), 0);
    chk("nowdog.ack", 32'(ack), 0);
    chk("nowdog.cyc_cnt", cyc_cnt, 100);
    finish(1, 101);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
